// File: rtl/alu_op_seq_pkg.sv
// alu_op_seq_pkg: shared widths and FSM state encoding for the ALU op sequencer
package alu_op_seq_pkg;
  localparam int OP_W        = 3;
  localparam int ISSUE_CNT_W = 8;
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, PAUSE = 2'd2} state_t;
endpackage

// File: rtl/alu_op_fifo.sv
// alu_op_fifo: synchronous DEPTH x OP_W opcode FIFO; caller guarantees push only when !full, pop only when !empty
module alu_op_fifo
  import alu_op_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic            pop,
  input  logic [OP_W-1:0] wdata,
  output logic [OP_W-1:0] rdata,
  output logic            full,
  output logic            empty
);
  localparam int AW = $clog2(DEPTH);
  logic [OP_W-1:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  assign full  = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign rdata = mem[rd_ptr];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= wdata;
endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: queues opcodes and presents each on the decoder selects for HOLD_CYCLES clocks
// Optional issue counter output enabled by defining ALU_OP_SEQ_COUNT_EN.
module alu_op_sequencer
  import alu_op_seq_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [OP_W-1:0]        in_op,
  output logic                   in_ready,
  input  logic                   pause,
  output logic                   sel_a,
  output logic                   sel_b,
  output logic                   sel_c,
  output logic                   sel_valid,
`ifdef ALU_OP_SEQ_COUNT_EN
  output logic [ISSUE_CNT_W-1:0] issue_cnt,
`endif
  output logic                   busy
);
  localparam int CW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] HOLD = CW'(HOLD_CYCLES);
  state_t          state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [OP_W-1:0] sel, sel_nx, head;
  logic            vld_nx, pop, full, empty;
  alu_op_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (in_valid && !full),
    .pop   (pop),
    .wdata (in_op),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );
  assign in_ready              = !full;
  assign busy                  = state != IDLE || !empty;
  assign {sel_c, sel_b, sel_a} = sel;
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    sel_nx   = sel;
    vld_nx   = sel_valid;
    pop      = 1'b0;
    case (state)
      IDLE:
        if (!empty && !pause) begin
          pop      = 1'b1;
          sel_nx   = head;
          vld_nx   = 1'b1;
          cnt_nx   = CW'(1);
          state_nx = ISSUE;
        end
      ISSUE:
        if (pause) begin
          state_nx = PAUSE;
          vld_nx   = 1'b0;
        end else if (cnt == HOLD) begin
          if (!empty) begin
            pop    = 1'b1;
            sel_nx = head;
            cnt_nx = CW'(1);
          end else begin
            state_nx = IDLE;
            vld_nx   = 1'b0;
          end
        end else cnt_nx = cnt + 1'b1;
      PAUSE:
        // the resume cycle is itself a presented cycle; saturate so a full hold still gets one more
        if (!pause) begin
          state_nx = ISSUE;
          vld_nx   = 1'b1;
          cnt_nx   = cnt == HOLD ? cnt : cnt + 1'b1;
        end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      sel       <= '0;
      sel_valid <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      sel       <= sel_nx;
      sel_valid <= vld_nx;
    end
`ifdef ALU_OP_SEQ_COUNT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) issue_cnt <= '0;
    else if (pop) issue_cnt <= issue_cnt + 1'b1;
`endif
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed literal checks plus randomized traffic against a queue-based reference model
module tb_alu_op_sequencer;
  localparam int DEPTH = 4;
  localparam int HOLD  = 2;
  logic       clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, pause = 1'b0;
  logic [2:0] in_op = '0;
  logic       in_ready, sel_a, sel_b, sel_c, sel_valid, busy;
`ifdef ALU_OP_SEQ_COUNT_EN
  logic [7:0] issue_cnt;
`endif
  int n_chk = 0, n_fail = 0;

  alu_op_sequencer #(.DEPTH(DEPTH), .HOLD_CYCLES(HOLD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_op     (in_op),
    .in_ready  (in_ready),
    .pause     (pause),
    .sel_a     (sel_a),
    .sel_b     (sel_b),
    .sel_c     (sel_c),
    .sel_valid (sel_valid),
`ifdef ALU_OP_SEQ_COUNT_EN
    .issue_cnt (issue_cnt),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of waiting ops plus the op on display and how many cycles it has shown.
  int q[$];
  int m_cur = 0, m_shown = 0, m_pops = 0;
  bit m_held = 0, m_valid = 0;

  task automatic model_reset();
    q.delete();
    m_cur = 0; m_shown = 0; m_pops = 0; m_held = 0; m_valid = 0;
  endtask

  task automatic model_step();
    bit take = 0;
    bit do_push = in_valid && q.size() < DEPTH;
    if (!m_held) take = q.size() > 0 && !pause;
    else if (m_valid) begin
      if (pause) m_valid = 0;
      else if (m_shown >= HOLD) begin
        if (q.size() > 0) take = 1;
        else begin m_held = 0; m_valid = 0; end
      end else m_shown++;
    end else if (!pause) begin
      m_valid = 1;
      if (m_shown < HOLD) m_shown++;
    end
    if (take) begin
      m_cur = q.pop_front(); m_held = 1; m_valid = 1; m_shown = 1; m_pops++;
    end
    if (do_push) q.push_back(int'(in_op));
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  initial forever begin
    @(negedge clk);
    chk("m_sel", {29'd0, sel_c, sel_b, sel_a}, m_cur);
    chk("m_sel_valid", 32'(sel_valid), 32'(m_valid));
    chk("m_in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
    chk("m_busy", 32'(busy), 32'(m_held || q.size() > 0));
`ifdef ALU_OP_SEQ_COUNT_EN
    chk("m_issue_cnt", 32'(issue_cnt), m_pops % 256);
`endif
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_op(int op);
    in_valid = 1'b1; in_op = 3'(op);
    cyc();
    in_valid = 1'b0;
  endtask

  initial begin
    int exp3[5] = '{5, 6, 7, 0, 3};
    int sent;
    cyc();
    chk("rst_sel_valid", 32'(sel_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    cyc();
    // single op latency and hold
    push_op(5);
    chk("t1_latency", 32'(sel_valid), 0);
    cyc(); chk("t1_sel", {29'd0, sel_c, sel_b, sel_a}, 5); chk("t1_v1", 32'(sel_valid), 1);
    cyc(); chk("t1_v2", 32'(sel_valid), 1);
    cyc(); chk("t1_done", 32'(sel_valid), 0); chk("t1_held", {29'd0, sel_c, sel_b, sel_a}, 5);
    chk("t1_busy", 32'(busy), 0);
    // fill while paused, then drain without gaps
    pause = 1'b1;
    for (int op = 1; op <= 4; op++) push_op(op);
    chk("t2_full", 32'(in_ready), 0);
    pause = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cyc();
      chk("t2_sel", {29'd0, sel_c, sel_b, sel_a}, k / 2 + 1);
      chk("t2_valid", 32'(sel_valid), 1);
    end
    cyc(); chk("t2_end", 32'(sel_valid), 0);
    // in_valid held through the full+pop cycle
    pause = 1'b1;
    foreach (exp3[i]) if (i < 4) push_op(exp3[i]);
    in_valid = 1'b1; in_op = 3'd3; pause = 1'b0;
    for (int k = 0; k <= 10; k++) begin
      cyc();
      if (k == 0) chk("t3_ready_after_pop", 32'(in_ready), 1);
      if (k == 1) begin chk("t3_refull", 32'(in_ready), 0); in_valid = 1'b0; end
      if (k % 2 == 0 && k < 10) chk("t3_order", {29'd0, sel_c, sel_b, sel_a}, exp3[k / 2]);
      if (k == 10) chk("t3_end", 32'(sel_valid), 0);
    end
    // pause during the first cycle of op 6
    push_op(6);
    cyc(); chk("t4_sel", {29'd0, sel_c, sel_b, sel_a}, 6); chk("t4_v", 32'(sel_valid), 1);
    pause = 1'b1;
    for (int k = 0; k < 3; k++) begin cyc(); chk("t4_paused", 32'(sel_valid), 0); end
    pause = 1'b0;
    cyc(); chk("t4_resume", 32'(sel_valid), 1); chk("t4_resume_sel", {29'd0, sel_c, sel_b, sel_a}, 6);
    cyc(); chk("t4_end", 32'(sel_valid), 0);
    // asynchronous reset with ops queued
    pause = 1'b1;
    push_op(7); push_op(1); push_op(2); push_op(3);
    pause = 1'b0;
    cyc(); cyc();
    chk("t5_busy_pre", 32'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(sel_valid), 0);
    chk("t5_rst_sel", {29'd0, sel_c, sel_b, sel_a}, 0);
    chk("t5_rst_ready", 32'(in_ready), 1);
    chk("t5_rst_busy", 32'(busy), 0);
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc(); chk("t5_idle_busy", 32'(busy), 0); chk("t5_idle_valid", 32'(sel_valid), 0);
    end
    // randomized traffic, with occasional asynchronous resets
    for (int k = 0; k < 1500; k++) begin
      in_valid = $urandom_range(0, 9) < 6;
      in_op = 3'($urandom);
      pause = $urandom_range(0, 9) < 2;
      if ($urandom_range(0, 299) == 0) begin
        #3 rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
      end else cyc();
    end
    in_valid = 1'b0; pause = 1'b0;
`ifdef ALU_OP_SEQ_COUNT_EN
    rst_n = 1'b0; cyc(); rst_n = 1'b1; cyc();
    sent = 0;
    for (int k = 0; k < 3000 && (sent < 257 || busy); k++) begin
      in_valid = sent < 257;
      in_op = 3'($urandom);
      if (in_valid && in_ready) sent++;
      cyc();
    end
    in_valid = 1'b0;
    chk("t6_drained", 32'(busy), 0);
    chk("t6_issue_cnt", 32'(issue_cnt), 1);
`else
    sent = 0;
    for (int k = 0; k < 20 && busy; k++) cyc();
    chk("drain_busy", 32'(busy) + 32'(sent), 0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
